wgt_load_ctrl: RTL and testbench

//   Sequences kernel-weight loading into the weight buffer feeding the 3x3 PE array.
//   Per kernel: one parallel read of the 3 weight-memory banks (one 32-bit row word each),

---
 rtl/cnn_pkg.sv | 21 ++
 rtl/wgt_addr_gen.sv | 62 ++++++
 rtl/wgt_load_ctrl.sv | 167 ++++++++++++++++
 tb/tb_wgt_load_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types and default sizes for the CNN datapath control blocks.
//   wgt_ctrl_state_t : weight-load sequencer states
//   WGT_ADDR_WIDTH   : default weight-memory word address width
//   WGT_CNT_WIDTH    : default kernel counter width
//   INPUT_WGT_REG    : number of weight-memory banks read in parallel per kernel
package cnn_pkg;

    localparam int WGT_ADDR_WIDTH = 16;
    localparam int WGT_CNT_WIDTH  = 10;
    localparam int INPUT_WGT_REG  = 3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_LOAD = 3'd3,
        ST_HOLD = 3'd4,
        ST_DONE = 3'd5
    } wgt_ctrl_state_t;

endpackage

// File: rtl/wgt_addr_gen.sv
// Kernel counter and weight-memory address accumulator.
//   clk, rst_n     : clock, async active-low reset
//   load_i         : restart at kernel 0 / base_i, latch num_i
//   step_i         : advance to next kernel (index+1, address+KERNEL_STRIDE)
//   base_i, num_i  : base address and kernel count, used on load_i
//   kernel_idx_o   : current kernel index
//   addr_o         : current bank word address
//   last_o         : current kernel is the final one (num-1)
import cnn_pkg::*;

module wgt_addr_gen #(
    parameter int ADDR_WIDTH    = WGT_ADDR_WIDTH,
    parameter int CNT_WIDTH     = WGT_CNT_WIDTH,
    parameter int KERNEL_STRIDE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic                  step_i,
    input  logic [ADDR_WIDTH-1:0] base_i,
    input  logic [CNT_WIDTH-1:0]  num_i,
    output logic [CNT_WIDTH-1:0]  kernel_idx_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  last_o
);

    logic [CNT_WIDTH-1:0]  cnt_q,  cnt_d;
    logic [CNT_WIDTH-1:0]  num_q,  num_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    always_comb begin
        cnt_d  = cnt_q;
        num_d  = num_q;
        addr_d = addr_q;
        if (load_i) begin
            cnt_d  = '0;
            num_d  = num_i;
            addr_d = base_i;
        end else if (step_i) begin
            cnt_d  = cnt_q + CNT_WIDTH'(1);
            // Running sum instead of idx*stride; wraps modulo 2^ADDR_WIDTH.
            addr_d = addr_q + ADDR_WIDTH'(KERNEL_STRIDE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            num_q  <= '0;
            addr_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            num_q  <= num_d;
            addr_q <= addr_d;
        end
    end

    assign kernel_idx_o = cnt_q;
    assign addr_o       = addr_q;
    assign last_o       = (cnt_q == num_q - CNT_WIDTH'(1));

endmodule

// File: rtl/wgt_load_ctrl.sv
// Kernel-weight load sequencer for the 3x3 PE array weight buffer.
// Each kernel: one parallel read of the weight-memory banks, a wgt_read strobe
// exactly MEM_LATENCY cycles later, then hold until the PE array releases it.
//   clk, rst_n        : clock, async active-low reset
//   start, abort      : start pulse (IDLE only), sync abort (highest priority)
//   base_addr         : address of kernel 0, latched on accepted start
//   num_kernels       : kernels to load, latched on accepted start
//   pe_done           : PE array finished current kernel (HOLD only)
//   mem_rd_en/addr    : read strobe and common address to all banks
//   wgt_read          : load strobe to the weight buffer
//   wgt_valid         : weight buffer holds the current kernel
//   kernel_idx        : kernel being loaded/held
//   busy, done        : not idle / one-cycle completion pulse
//
// state | meaning
// IDLE  | waiting for start
// REQ   | mem_rd_en issued for current kernel
// WAIT  | counting down remaining memory latency
// LOAD  | bank data valid, wgt_read strobe
// HOLD  | kernel in weight buffer, waiting for pe_done
// DONE  | one-cycle done pulse after last kernel
import cnn_pkg::*;

module wgt_load_ctrl #(
    parameter int ADDR_WIDTH    = WGT_ADDR_WIDTH,
    parameter int CNT_WIDTH     = WGT_CNT_WIDTH,
    parameter int KERNEL_STRIDE = 1,
    parameter int MEM_LATENCY   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  num_kernels,
    input  logic                  pe_done,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    output logic                  wgt_read,
    output logic                  wgt_valid,
    output logic [CNT_WIDTH-1:0]  kernel_idx,
    output logic                  busy,
    output logic                  done
);

    localparam int LAT_W = $clog2(MEM_LATENCY + 1);

    wgt_ctrl_state_t  state_q;
    logic [LAT_W-1:0] lat_cnt_q;
    logic             mem_rd_en_q;
    logic             wgt_read_q;
    logic             wgt_valid_q;
    logic             busy_q;
    logic             done_q;

    logic             ag_load;
    logic             ag_step;
    logic             ag_last;

    assign ag_load = (state_q == ST_IDLE) && start && !abort;
    assign ag_step = (state_q == ST_HOLD) && pe_done && !abort && !ag_last;

    wgt_addr_gen #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .CNT_WIDTH     (CNT_WIDTH),
        .KERNEL_STRIDE (KERNEL_STRIDE)
    ) u_addr_gen (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (ag_load),
        .step_i       (ag_step),
        .base_i       (base_addr),
        .num_i        (num_kernels),
        .kernel_idx_o (kernel_idx),
        .addr_o       (mem_rd_addr),
        .last_o       (ag_last)
    );

    // Output flags are registered with the state they belong to, so each
    // strobe is set on the transition into its state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            lat_cnt_q   <= '0;
            mem_rd_en_q <= 1'b0;
            wgt_read_q  <= 1'b0;
            wgt_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            mem_rd_en_q <= 1'b0;
            wgt_read_q  <= 1'b0;
            done_q      <= 1'b0;
            if (abort && (state_q != ST_IDLE)) begin
                state_q     <= ST_IDLE;
                lat_cnt_q   <= '0;
                wgt_valid_q <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            busy_q <= 1'b1;
                            if (num_kernels == '0) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q     <= ST_REQ;
                                mem_rd_en_q <= 1'b1;
                            end
                        end
                    end
                    ST_REQ: begin
                        if (MEM_LATENCY == 1) begin
                            state_q    <= ST_LOAD;
                            wgt_read_q <= 1'b1;
                        end else begin
                            state_q   <= ST_WAIT;
                            lat_cnt_q <= LAT_W'(MEM_LATENCY - 1);
                        end
                    end
                    ST_WAIT: begin
                        // Leave as the count hits zero so LOAD lands exactly
                        // MEM_LATENCY cycles after REQ.
                        lat_cnt_q <= lat_cnt_q - LAT_W'(1);
                        if (lat_cnt_q == LAT_W'(1)) begin
                            state_q    <= ST_LOAD;
                            wgt_read_q <= 1'b1;
                        end
                    end
                    ST_LOAD: begin
                        state_q     <= ST_HOLD;
                        wgt_valid_q <= 1'b1;
                    end
                    ST_HOLD: begin
                        if (pe_done) begin
                            wgt_valid_q <= 1'b0;
                            if (ag_last) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q     <= ST_REQ;
                                mem_rd_en_q <= 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q     <= ST_IDLE;
                        wgt_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign mem_rd_en = mem_rd_en_q;
    assign wgt_read  = wgt_read_q;
    assign wgt_valid = wgt_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_wgt_load_ctrl.sv
module tb_wgt_load_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start, start1;
    logic        abort;
    logic [15:0] base_addr;
    logic [9:0]  num_kernels;
    logic        pe_done, pe_done1;

    logic        mem_rd_en, wgt_read, wgt_valid, busy, done;
    logic [15:0] mem_rd_addr;
    logic [9:0]  kernel_idx;

    logic        mem_rd_en1, wgt_read1, wgt_valid1, busy1, done1;
    logic [15:0] mem_rd_addr1;
    logic [9:0]  kernel_idx1;

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;

    wgt_load_ctrl #(.ADDR_WIDTH(16), .CNT_WIDTH(10), .KERNEL_STRIDE(1), .MEM_LATENCY(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .base_addr   (base_addr),
        .num_kernels (num_kernels),
        .pe_done     (pe_done),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .wgt_read    (wgt_read),
        .wgt_valid   (wgt_valid),
        .kernel_idx  (kernel_idx),
        .busy        (busy),
        .done        (done)
    );

    wgt_load_ctrl #(.ADDR_WIDTH(16), .CNT_WIDTH(10), .KERNEL_STRIDE(1), .MEM_LATENCY(1)) dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start1),
        .abort       (abort),
        .base_addr   (base_addr),
        .num_kernels (num_kernels),
        .pe_done     (pe_done1),
        .mem_rd_en   (mem_rd_en1),
        .mem_rd_addr (mem_rd_addr1),
        .wgt_read    (wgt_read1),
        .wgt_valid   (wgt_valid1),
        .kernel_idx  (kernel_idx1),
        .busy        (busy1),
        .done        (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // {mem_rd_en, wgt_read, wgt_valid, busy, done}
    function automatic logic [31:0] flags();
        return {27'd0, mem_rd_en, wgt_read, wgt_valid, busy, done};
    endfunction

    function automatic logic [31:0] flags1();
        return {27'd0, mem_rd_en1, wgt_read1, wgt_valid1, busy1, done1};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Entered at the negedge where dut has just entered REQ for kernel k.
    task automatic run_kernel(input int k, input logic [15:0] a, input bit last);
        pe_done = 1'b0;
        chk("req_flags", flags(), 32'b10010);
        chk("req_addr", {16'd0, mem_rd_addr}, {16'd0, a});
        chk("req_kidx", {22'd0, kernel_idx}, k);
        @(negedge clk);
        chk("wait_flags", flags(), 32'b00010);
        @(negedge clk);
        chk("load_flags", flags(), 32'b01010);
        @(negedge clk);
        chk("hold_flags", flags(), 32'b00110);
        chk("hold_addr", {16'd0, mem_rd_addr}, {16'd0, a});
        chk("hold_kidx", {22'd0, kernel_idx}, k);
        repeat (2) @(negedge clk);
        chk("hold2_flags", flags(), 32'b00110);
        @(negedge clk);
        pe_done = 1'b1;
        @(negedge clk);
        pe_done = 1'b0;
        if (last) begin
            chk("done_flags", flags(), 32'b00011);
            chk("done_kidx", {22'd0, kernel_idx}, k);
            @(negedge clk);
            chk("idle_flags", flags(), 32'b00000);
            chk("idle_kidx", {22'd0, kernel_idx}, k);
        end
    endtask

    task automatic do_start(input logic [15:0] b, input logic [9:0] n);
        base_addr   = b;
        num_kernels = n;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        base_addr   = 16'hDEAD;
        num_kernels = 10'd7;
    endtask

    int d0;

    initial begin
        rst_n = 1'b0; start = 1'b0; start1 = 1'b0; abort = 1'b0;
        base_addr = '0; num_kernels = '0; pe_done = 1'b0; pe_done1 = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_flags", flags(), 32'b00000);
        chk("rst_addr", {16'd0, mem_rd_addr}, 32'd0);
        chk("rst_kidx", {22'd0, kernel_idx}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: three kernels from 0x0100
        d0 = done_cnt;
        do_start(16'h0100, 10'd3);
        run_kernel(0, 16'h0100, 1'b0);
        run_kernel(1, 16'h0101, 1'b0);
        run_kernel(2, 16'h0102, 1'b1);
        chk("t1_done_count", done_cnt - d0, 32'd1);

        // 2: zero kernels
        d0 = done_cnt;
        do_start(16'h0040, 10'd0);
        chk("t2_done_flags", flags(), 32'b00011);
        @(negedge clk);
        chk("t2_idle_flags", flags(), 32'b00000);
        chk("t2_done_count", done_cnt - d0, 32'd1);

        // 3: address wrap
        do_start(16'hFFFE, 10'd4);
        run_kernel(0, 16'hFFFE, 1'b0);
        run_kernel(1, 16'hFFFF, 1'b0);
        run_kernel(2, 16'h0000, 1'b0);
        run_kernel(3, 16'h0001, 1'b1);

        // 4: abort in WAIT of kernel 1, then fresh start
        d0 = done_cnt;
        do_start(16'h0200, 10'd3);
        run_kernel(0, 16'h0200, 1'b0);
        chk("t4_req1_flags", flags(), 32'b10010);
        chk("t4_req1_addr", {16'd0, mem_rd_addr}, 32'h0201);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t4_abort_flags", flags(), 32'b00000);
        @(negedge clk);
        chk("t4_no_load_flags", flags(), 32'b00000);
        chk("t4_no_done", done_cnt - d0, 32'd0);
        do_start(16'h0300, 10'd1);
        run_kernel(0, 16'h0300, 1'b1);

        // 5: start and pe_done ignored while busy; start+abort in IDLE
        do_start(16'h0400, 10'd2);
        chk("t5_req_flags", flags(), 32'b10010);
        start = 1'b1; pe_done = 1'b1;
        @(negedge clk);
        chk("t5_wait_flags", flags(), 32'b00010);
        chk("t5_wait_kidx", {22'd0, kernel_idx}, 32'd0);
        @(negedge clk);
        start = 1'b0; pe_done = 1'b0;
        chk("t5_load_flags", flags(), 32'b01010);
        @(negedge clk);
        chk("t5_hold_flags", flags(), 32'b00110);
        chk("t5_hold_kidx", {22'd0, kernel_idx}, 32'd0);
        chk("t5_hold_addr", {16'd0, mem_rd_addr}, 32'h0400);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t5_abort_flags", flags(), 32'b00000);
        base_addr = 16'h0500; num_kernels = 10'd1;
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("t5_start_abort_flags", flags(), 32'b00000);
        @(negedge clk);
        chk("t5_still_idle", flags(), 32'b00000);

        // 6: MEM_LATENCY=1 build, async reset in HOLD
        base_addr = 16'h0050; num_kernels = 10'd2;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("t6_req_flags", flags1(), 32'b10010);
        chk("t6_req_addr", {16'd0, mem_rd_addr1}, 32'h0050);
        @(negedge clk);
        chk("t6_load_flags", flags1(), 32'b01010);
        @(negedge clk);
        chk("t6_hold_flags", flags1(), 32'b00110);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_flags", flags1(), 32'b00000);
        chk("t6_rst_addr", {16'd0, mem_rd_addr1}, 32'd0);
        chk("t6_rst_kidx", {22'd0, kernel_idx1}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_after_rst_flags", flags1(), 32'b00000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
